tdc_readout_ctrl: RTL

Readout sequencer for the TDC fine-time path. It samples the 32-bit delay-line thermometer code and a free-running coarse counter on each hit, and converts the thermometer code to a 6-bit fine count by serial popcount, one byte per cycle. It packs `{coarse, fine}` into a small FIFO drained through a valid/ready interface. It sits between the delay-line sampling registers and the readout/UART logic, and replaces a free-running combinational encoder with a controlled, back-pressured conversion.

---
 rtl/tdc_readout_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/tdc_readout_ctrl.sv
// tdc_readout_ctrl
//   Readout sequencer for the TDC fine-time path. On an accepted hit it
//   captures the 32-bit delay-line thermometer code and the free-running
//   coarse counter. It converts the code to a 6-bit fine count by serial
//   popcount, one byte per cycle over four cycles. It then pushes
//   {coarse, fine} into a small FIFO that is drained through valid/ready.
//
// Parameters
//   COARSE_WIDTH  coarse counter width (default 8)
//   FIFO_DEPTH    output FIFO entries, power of 2, >= 2 (default 4)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           acquisition enable
//   hit          one-cycle hit strobe, thermo valid in the same cycle
//   thermo       sampled thermometer code
//   data_out     FIFO head: [COARSE_WIDTH+5:6] coarse, [5:0] fine
//   data_valid   FIFO not empty
//   data_ready   consumer accepts data_out
//   busy         registered, high while in ENCODE or WRITE
//   fifo_full    FIFO holds FIFO_DEPTH words
//   dropped_cnt  saturating count of lost hits (only with TDC_DROP_CNT_EN)
//
// Build option
//   TDC_DROP_CNT_EN : when defined, adds the dropped_cnt port and counter.

module tdc_readout_ctrl #(
  parameter int COARSE_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    hit,
  input  logic [31:0]             thermo,
  output logic [COARSE_WIDTH+5:0] data_out,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic                    busy,
  output logic                    fifo_full
`ifdef TDC_DROP_CNT_EN
  ,
  output logic [7:0]              dropped_cnt
`endif
);

  localparam int DW = COARSE_WIDTH + 6;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ENCODE = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_busy;
  logic                    w_busy_next;

  logic [COARSE_WIDTH-1:0] r_coarse;
  logic [COARSE_WIDTH-1:0] r_coarse_q;
  logic [31:0]             r_thermo_q;
  logic [5:0]              r_acc;
  logic [1:0]              r_step;

  logic [DW-1:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [PW:0]             r_count;

  logic                    w_accept_hit;
  logic                    w_pop;
  logic                    w_push;
  logic [7:0]              w_byte;
  logic [3:0]              w_byte_ones;

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c + {3'b000, b[i]};
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= w_busy_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (en) w_state_next = S_ARMED;
      // Dropping en wins over a coincident hit.
      S_ARMED:  if (!en) w_state_next = S_IDLE;
                else if (hit) w_state_next = S_ENCODE;
      S_ENCODE: if (r_step == 2'd3) w_state_next = S_WRITE;
      S_WRITE:  w_state_next = en ? S_ARMED : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs / control strobes
  // ---------------------------------------------------------------------
  always_comb begin
    w_busy_next  = (w_state_next == S_ENCODE) || (w_state_next == S_WRITE);
    w_accept_hit = (r_state == S_ARMED) && en && hit;
    w_pop        = data_valid && data_ready;
    // A full FIFO still takes the word when a pop frees a slot this cycle.
    w_push       = (r_state == S_WRITE) && (!fifo_full || w_pop);
    w_byte       = r_thermo_q[{r_step, 3'b000} +: 8];
    w_byte_ones  = popcount8(w_byte);
  end

  // ---------------------------------------------------------------------
  // Coarse counter and conversion datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_coarse   <= '0;
      r_coarse_q <= '0;
      r_thermo_q <= '0;
      r_acc      <= '0;
      r_step     <= '0;
    end else begin
      // Zero both while sitting in IDLE and on the edge that enters it,
      // so the first ARMED cycle always starts counting from 0.
      if ((r_state == S_IDLE) || (w_state_next == S_IDLE)) begin
        r_coarse <= '0;
      end else begin
        r_coarse <= r_coarse + 1'b1;
      end

      if (w_accept_hit) begin
        r_thermo_q <= thermo;
        r_coarse_q <= r_coarse;
        r_acc      <= '0;
        r_step     <= '0;
      end else if (r_state == S_ENCODE) begin
        r_acc  <= r_acc + {2'b00, w_byte_ones};
        r_step <= r_step + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_coarse_q, r_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_valid = (r_count != '0);
  assign fifo_full  = (r_count == FULL_CNT);
  // Storage is not reset, so the head is forced to zero while empty.
  assign data_out   = data_valid ? r_mem[r_rd_ptr] : '0;
  assign busy       = r_busy;

`ifdef TDC_DROP_CNT_EN
  // ---------------------------------------------------------------------
  // Lost-hit counter: ignored hits plus discarded writes, saturating
  // ---------------------------------------------------------------------
  logic [7:0] r_dropped;
  logic       w_drop_hit;
  logic       w_drop_write;
  logic [8:0] w_drop_sum;

  always_comb begin
    w_drop_hit   = hit && ((r_state == S_ENCODE) || (r_state == S_WRITE));
    w_drop_write = (r_state == S_WRITE) && !w_push;
    w_drop_sum   = {1'b0, r_dropped} + {8'd0, w_drop_hit} + {8'd0, w_drop_write};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropped <= '0;
    end else begin
      r_dropped <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign dropped_cnt = r_dropped;
`endif

endmodule
